// File: rtl/dac_peak_monitor.sv
// Peak and clip monitor for the super-sample DAC bus. A three-stage abs/max/popcount
// pipeline feeds an interval accumulator that publishes peak and clip count per interval.
module dac_peak_monitor #(
    parameter int NUMBER_OF_LINE = 8,
    parameter int LEN_WIDTH      = 24
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [LEN_WIDTH-1:0]        interval_length,
    input  logic [15:0]                 clip_threshold,
    input  logic [16*NUMBER_OF_LINE-1:0] dac_data,
    output logic [15:0]                 interval_max,
    output logic [15:0]                 interval_clip_count,
    output logic                        interval_valid
);

    localparam int HALF  = NUMBER_OF_LINE / 2;
    localparam int CNT_W = $clog2(NUMBER_OF_LINE + 1);

    // Datapath stages
    logic [15:0]      abs_d [NUMBER_OF_LINE];
    logic [15:0]      abs_q [NUMBER_OF_LINE];
    logic [15:0]      pmax_d [HALF];
    logic [15:0]      pmax_q [HALF];
    logic [15:0]      max_tree [HALF];
    logic [CNT_W-1:0] clip2_d, clip2_q;
    logic [15:0]      beat_max_d, beat_max_q;
    logic [CNT_W-1:0] beat_clip_d, beat_clip_q;

    // Control and accumulator
    logic                 v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic [LEN_WIDTH-1:0] beat_cnt_d, beat_cnt_q;
    logic [LEN_WIDTH-1:0] len_d, len_q;
    logic [15:0]          acc_max_d, acc_max_q;
    logic [15:0]          acc_clip_d, acc_clip_q;
    logic [15:0]          out_max_d, out_max_q;
    logic [15:0]          out_clip_d, out_clip_q;
    logic                 out_valid_d, out_valid_q;

    logic                 first_beat;
    logic [LEN_WIDTH-1:0] eff_len;
    logic [15:0]          merged_max;
    logic [16:0]          clip_sum;
    logic [15:0]          merged_clip;

    // S1: per-lane magnitude; -32768 clamps to 32767 so the result fits 15 bits.
    always_comb begin
        logic [15:0] s;
        v1_d = enable;
        for (int i = 0; i < NUMBER_OF_LINE; i++) begin
            s = dac_data[16*i +: 16];
            if (!s[15])              abs_d[i] = s;
            else if (s == 16'h8000)  abs_d[i] = 16'h7FFF;
            else                     abs_d[i] = ~s + 16'd1;
        end
    end

    // S2: pairwise max and clip popcount.
    always_comb begin
        v2_d    = v1_q;
        clip2_d = '0;
        for (int i = 0; i < HALF; i++)
            pmax_d[i] = (abs_q[2*i] > abs_q[2*i+1]) ? abs_q[2*i] : abs_q[2*i+1];
        for (int i = 0; i < NUMBER_OF_LINE; i++)
            if (abs_q[i] > clip_threshold) clip2_d = clip2_d + CNT_W'(1);
    end

    // S3: balanced max tree over the pair maxima; odd leftovers pass through a level.
    always_comb begin
        v3_d        = v2_q;
        beat_clip_d = clip2_q;
        max_tree    = pmax_q;
        for (int w = HALF; w > 1; w = (w + 1) / 2) begin
            for (int i = 0; i < w / 2; i++)
                max_tree[i] = (max_tree[2*i] > max_tree[2*i+1]) ? max_tree[2*i] : max_tree[2*i+1];
            if (w % 2 == 1) max_tree[w/2] = max_tree[w-1];
        end
        beat_max_d = max_tree[0];
    end

    // S4: interval accumulator; the interval length is latched on its first beat.
    always_comb begin
        first_beat  = (beat_cnt_q == '0);
        eff_len     = first_beat ? ((interval_length == '0) ? LEN_WIDTH'(1) : interval_length) : len_q;
        merged_max  = (first_beat || beat_max_q > acc_max_q) ? beat_max_q : acc_max_q;
        clip_sum    = {1'b0, acc_clip_q} + 17'(beat_clip_q);
        merged_clip = first_beat ? 16'(beat_clip_q) : (clip_sum[16] ? 16'hFFFF : clip_sum[15:0]);

        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        acc_max_d   = acc_max_q;
        acc_clip_d  = acc_clip_q;
        out_max_d   = out_max_q;
        out_clip_d  = out_clip_q;
        out_valid_d = 1'b0;

        if (v3_q) begin
            len_d      = eff_len;
            acc_max_d  = merged_max;
            acc_clip_d = merged_clip;
            if (beat_cnt_q == eff_len - LEN_WIDTH'(1)) begin
                out_max_d   = merged_max;
                out_clip_d  = merged_clip;
                out_valid_d = 1'b1;
                beat_cnt_d  = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    // NOTE: datapath stages carry no reset; the valid tags alone decide whether they are used.
    always_ff @(posedge clock) begin
        abs_q       <= abs_d;
        pmax_q      <= pmax_d;
        clip2_q     <= clip2_d;
        beat_max_q  <= beat_max_d;
        beat_clip_q <= beat_clip_d;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            acc_max_q   <= '0;
            acc_clip_q  <= '0;
            out_max_q   <= '0;
            out_clip_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            v3_q        <= v3_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            acc_max_q   <= acc_max_d;
            acc_clip_q  <= acc_clip_d;
            out_max_q   <= out_max_d;
            out_clip_q  <= out_clip_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign interval_max        = out_max_q;
    assign interval_clip_count = out_clip_q;
    assign interval_valid      = out_valid_q;

endmodule

// File: tb/tb_dac_peak_monitor.sv
// Directed bench for dac_peak_monitor: strobes are logged with their cycle number and
// compared against hand-computed peak, clip count and 4-cycle latency.
module tb_dac_peak_monitor;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic [23:0]  interval_length = 24'd4;
    logic [15:0]  clip_threshold = 16'd1000;
    logic [127:0] dac_data = '0;
    logic [15:0]  interval_max;
    logic [15:0]  interval_clip_count;
    logic         interval_valid;

    dac_peak_monitor #(.NUMBER_OF_LINE(8), .LEN_WIDTH(24)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .enable              (enable),
        .interval_length     (interval_length),
        .clip_threshold      (clip_threshold),
        .dac_data            (dac_data),
        .interval_max        (interval_max),
        .interval_clip_count (interval_clip_count),
        .interval_valid      (interval_valid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [15:0] mx;
        logic [15:0] cl;
    } strobe_t;
    strobe_t sq[$];

    always @(negedge clock)
        if (reset_n && interval_valid)
            sq.push_back('{cyc: cyc, mx: interval_max, cl: interval_clip_count});

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] mk8(input int a0, a1, a2, a3, a4, a5, a6, a7);
        logic [127:0] r;
        r = {a7[15:0], a6[15:0], a5[15:0], a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
        return r;
    endfunction

    function automatic logic [127:0] fill(input int v);
        return mk8(v, v, v, v, v, v, v, v);
    endfunction

    function automatic logic [127:0] alt(input int v);
        return mk8(v, -v, v, -v, v, -v, v, -v);
    endfunction

    // Drive one cycle of input; c returns the cycle in which the beat was presented.
    task automatic send(input logic en, input logic [127:0] d, output int c);
        c        = cyc;
        enable   = en;
        dac_data = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        int c;
        for (int i = 0; i < n; i++) send(1'b0, '0, c);
    endtask

    task automatic reset_dut(input int n);
        int c;
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            send(1'b1, {$urandom, $urandom, $urandom, $urandom}, c);
            check("rst_valid", 32'(interval_valid), 32'd0);
            check("rst_max", 32'(interval_max), 32'd0);
            check("rst_clip", 32'(interval_clip_count), 32'd0);
        end
        reset_n = 1'b1;
        sq.delete();
    endtask

    task automatic chk_strobe(input string tag, input int idx, input int exp_cyc,
                              input logic [15:0] exp_max, input logic [15:0] exp_clip);
        if (idx < sq.size()) begin
            check({tag, "_cyc"}, 32'(sq[idx].cyc), 32'(exp_cyc));
            check({tag, "_max"}, 32'(sq[idx].mx), 32'(exp_max));
            check({tag, "_clip"}, 32'(sq[idx].cl), 32'(exp_clip));
        end else begin
            check({tag, "_missing"}, 32'(sq.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int c, c0, c1, c2;
        int bc[6];
        logic [127:0] dv[6];
        logic [15:0]  em[6];
        logic [15:0]  ec[6];

        // Reset, then peak / abs(-32768) corner with len=4.
        interval_length = 24'd4;
        clip_threshold  = 16'd1000;
        reset_dut(5);
        check("post_rst_no_strobe", 32'(sq.size()), 32'd0);
        send(1'b1, fill(0), c0);
        send(1'b1, fill(0), c);
        send(1'b1, mk8(0, 0, 0, 0, 0, -32768, 0, 0), c);
        send(1'b1, fill(0), c);
        send(1'b1, alt(100), c);
        send(1'b1, alt(100), c);
        send(1'b1, alt(100), c);
        send(1'b1, alt(100), c1);
        idle(6);
        check("peak_count", 32'(sq.size()), 32'd2);
        chk_strobe("peak_first", 0, c0 + 3 + 4, 16'h7FFF, 16'd1);
        chk_strobe("peak_second", 1, c1 + 4, 16'd100, 16'd0);
        check("hold_max", 32'(interval_max), 32'd100);
        check("hold_valid", 32'(interval_valid), 32'd0);
        sq.delete();

        // Clip count over threshold boundaries.
        interval_length = 24'd2;
        clip_threshold  = 16'd1000;
        send(1'b1, mk8(0, 999, 1000, 1001, -1001, -1000, 32767, -32768), c);
        send(1'b1, mk8(0, 999, 1000, 1001, -1001, -1000, 32767, -32768), c1);
        idle(6);
        check("clip_count_n", 32'(sq.size()), 32'd1);
        chk_strobe("clip", 0, c1 + 4, 16'h7FFF, 16'd8);
        sq.delete();

        // Enable gaps: disabled beats carry large values that must be ignored.
        interval_length = 24'd3;
        clip_threshold  = 16'd250;
        send(1'b1, fill(300), c);
        send(1'b0, fill(30000), c);
        send(1'b0, fill(30000), c);
        send(1'b1, fill(-700), c);
        send(1'b0, fill(30000), c);
        send(1'b1, fill(200), c1);
        idle(6);
        check("gap_count", 32'(sq.size()), 32'd1);
        chk_strobe("gap", 0, c1 + 4, 16'd700, 16'd16);
        sq.delete();

        // len=0 behaves as 1: a strobe every cycle, one beat each.
        interval_length = 24'd0;
        clip_threshold  = 16'd1000;
        dv = '{fill(5), alt(1234), fill(-32768), fill(0), mk8(0, 0, 0, 0, 0, 0, 0, -999), alt(1001)};
        em = '{16'd5, 16'd1234, 16'h7FFF, 16'd0, 16'd999, 16'd1001};
        ec = '{16'd0, 16'd8, 16'd8, 16'd0, 16'd0, 16'd8};
        for (int i = 0; i < 6; i++) send(1'b1, dv[i], bc[i]);
        idle(6);
        check("len0_count", 32'(sq.size()), 32'd6);
        for (int i = 0; i < 6; i++) chk_strobe($sformatf("len0_%0d", i), i, bc[i] + 4, em[i], ec[i]);
        sq.delete();

        // Reset mid-interval discards the partial interval.
        interval_length = 24'd10;
        for (int i = 0; i < 5; i++) send(1'b1, fill(20000), c);
        reset_dut(2);
        for (int i = 0; i < 10; i++) send(1'b1, (i == 6) ? alt(400) : fill(150), c1);
        idle(6);
        check("midrst_count", 32'(sq.size()), 32'd1);
        chk_strobe("midrst", 0, c1 + 4, 16'd400, 16'd0);
        sq.delete();

        // Length change mid-interval applies from the next interval on.
        interval_length = 24'd10;
        clip_threshold  = 16'd115;
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) interval_length = 24'd2;
            send(1'b1, fill(k * 10), c0);
        end
        send(1'b1, fill(110), c);
        send(1'b1, fill(120), c1);
        send(1'b1, fill(130), c);
        send(1'b1, fill(140), c2);
        idle(6);
        check("lenchg_count", 32'(sq.size()), 32'd3);
        chk_strobe("lenchg_10", 0, c0 + 4, 16'd100, 16'd0);
        chk_strobe("lenchg_2a", 1, c1 + 4, 16'd120, 16'd8);
        chk_strobe("lenchg_2b", 2, c2 + 4, 16'd140, 16'd16);
        sq.delete();

        // Clip saturation: 8200 beats x 8 clips overflows 16 bits; next interval restarts.
        interval_length = 24'd8200;
        clip_threshold  = 16'd0;
        for (int i = 0; i < 8200; i++) send(1'b1, fill(1), c1);
        idle(6);
        interval_length = 24'd1;
        send(1'b1, fill(-3), c2);
        idle(6);
        check("sat_count", 32'(sq.size()), 32'd2);
        chk_strobe("sat", 0, c1 + 4, 16'd1, 16'hFFFF);
        chk_strobe("sat_clear", 1, c2 + 4, 16'd3, 16'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
